// File: rtl/mux_sched.sv
// mux_sched: two-input token scheduler driving 4-phase mux-select and conditional-sink channels
module mux_sched #(
    parameter int CNT_W = 8,
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [1:0]       pend,
    output logic             sel_req,
    output logic             sel_dat,
    input  logic             sel_ack,
    output logic             snk_req,
    output logic             snk_dat,
    input  logic             snk_ack,
    input  logic [PAT_W-1:0] pattern,
    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1,
    output logic             busy
);
    localparam int TW = PAT_W > 1 ? $clog2(PAT_W) : 1;

    typedef enum logic [2:0] {IDLE, SEL_UP, SEL_DN, SNK_UP, SNK_DN} state_t;

    state_t        state, state_n;
    logic          last, win_c;
    logic [TW-1:0] tok_idx;

    assign win_c = (mode && &pend) ? ~last : ~pend[0];
    assign busy  = state != IDLE;

    // next-state: IDLE decides, each handshake phase waits on its ack level
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (en && |pend) ? SEL_UP : IDLE;
            SEL_UP:  state_n = sel_ack ? SEL_DN : SEL_UP;
            SEL_DN:  state_n = sel_ack ? SEL_DN : SNK_UP;
            SNK_UP:  state_n = snk_ack ? SNK_DN : SNK_UP;
            SNK_DN:  state_n = snk_ack ? SNK_DN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state, registered channel outputs, winner/pattern capture and completion bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_req <= 1'b0;
            sel_dat <= 1'b0;
            snk_req <= 1'b0;
            snk_dat <= 1'b0;
            gcnt0   <= '0;
            gcnt1   <= '0;
            tok_idx <= '0;
            last    <= 1'b1;
        end else begin
            state   <= state_n;
            sel_req <= state_n == SEL_UP;
            snk_req <= state_n == SNK_UP;
            if (state == IDLE && state_n == SEL_UP)
                sel_dat <= win_c;
            if (state == SEL_DN && state_n == SNK_UP)
                snk_dat <= pattern[tok_idx];
            if (state == SNK_DN && state_n == IDLE) begin
                last    <= sel_dat;
                tok_idx <= tok_idx == TW'(PAT_W - 1) ? '0 : tok_idx + TW'(1);
                if (sel_dat)
                    gcnt1 <= gcnt1 + CNT_W'(1);
                else
                    gcnt0 <= gcnt0 + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/mux_sched.md
MUX_SCHED -- requirements
Module: mux_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each grant counter.
REQ-002 SHALL have parameter PAT_W, default 8, length of the sink pass/drop pattern.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  1 = scheduling enabled; 0 = no new arbitration starts.
REQ-006 SHALL have port mode  input  1  1 = round-robin; 0 = fixed priority, input 0 highest.
REQ-007 SHALL have port pend  input  2  pend[i]=1: mux input i holds a token awaiting selection.
REQ-008 SHALL have ports sel_req output 1, sel_dat output 1, sel_ack input 1: 4-phase mux select channel; sel_dat = chosen input index.
REQ-009 SHALL have ports snk_req output 1, snk_dat output 1, snk_ack input 1: 4-phase conditional-sink control channel; snk_dat 1 = pass, 0 = drop.
REQ-010 SHALL have port pattern  input  PAT_W  pass/drop bit per token, indexed by token count.
REQ-011 SHALL have ports gcnt0, gcnt1  output  CNT_W  completed grants per input.
REQ-012 SHALL have port busy  output  1  1 whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SEL_UP, SEL_DN, SNK_UP, SNK_DN.
REQ-014 IDLE: if en=1 and pend!=0, SHALL choose a winner, register it, and go to SEL_UP next cycle; otherwise stay.
REQ-015 Winner, mode=0: input 0 if pend[0], else input 1.
REQ-016 Winner, mode=1: if both pending, input != last winner; if one pending, that one; last winner resets to 1 so input 0 wins first.
REQ-017 SEL_UP: sel_req=1, sel_dat=winner held stable; on sel_ack=1 -> SEL_DN.
REQ-018 SEL_DN: sel_req=0, sel_dat still held; on sel_ack=0 -> SNK_UP.
REQ-019 SNK_UP: snk_req=1, snk_dat=pattern[tok_idx]; on snk_ack=1 -> SNK_DN.
REQ-020 SNK_DN: snk_req=0, snk_dat held; on snk_ack=0 -> IDLE, same edge: increment winner's gcnt, tok_idx, update last winner.
REQ-021 tok_idx SHALL count 0..PAT_W-1 and wrap to 0; gcnt SHALL wrap modulo 2^CNT_W.
REQ-022 Per transaction: 1 cycle min per state, so ≥5 cycles from IDLE decision to return to IDLE with ack responding in 1 cycle.
REQ-023 sel_req/snk_req SHALL be registered outputs, never both 1 in the same cycle.
REQ-024 en or pend changing after leaving IDLE SHALL NOT abort the transaction; both are sampled only in IDLE.
REQ-025 pattern SHALL be sampled on entry to SNK_UP and held until SNK_DN exits.
REQ-026 An ack already high at entry to SEL_UP/SNK_UP SHALL be accepted next edge; no extra wait required.
REQ-027 busy SHALL equal (state != IDLE), combinational from state register.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state IDLE, sel_req=0, sel_dat=0, snk_req=0, snk_dat=0, gcnt0=gcnt1=0, tok_idx=0, last winner=1, busy=0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no counter increment; outputs reach reset values on the next edge.

Verification
REQ-030 mode=1, pend=2'b11 constant, 1-cycle ack responder, 4 transactions -> sel_dat sequence 0,1,0,1; gcnt0=2, gcnt1=2.
REQ-031 mode=0, pend=2'b11, 3 transactions -> sel_dat always 0; gcnt0=3, gcnt1=0.
REQ-032 pattern=8'b0000_0101, 10 transactions -> snk_dat 1,0,1,0,0,0,0,0,1,0 (wrap at 8).
REQ-033 sel_ack delayed 5 cycles in SEL_UP -> sel_req stays 1, sel_dat stable, snk_req=0 throughout.
REQ-034 rst_n=0 during SNK_UP -> next cycle snk_req=0, busy=0, counters unchanged from 0 / previous reset values.
REQ-035 en=0 with pend=2'b11 for 20 cycles -> busy=0, sel_req=0; en deasserted in SEL_DN -> transaction still completes.
